// File: rtl/z_result_stage_if.sv
// Handshake bundle for z_result_stage: start/op/ALU words in, captured
// result, HI/LO words and status out. master = producer side, slave = DUT.
interface z_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] alu_lo;
    logic             flush;
    logic             z_ready;
    logic             z_valid;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy;
    logic             overrun;

    modport master (
        output start, op, alu_hi, alu_lo, flush, z_ready,
        input  z_valid, z_hi, z_lo, hi_reg, lo_reg, busy, overrun
    );

    modport slave (
        input  start, op, alu_hi, alu_lo, flush, z_ready,
        output z_valid, z_hi, z_lo, hi_reg, lo_reg, busy, overrun
    );
endinterface

// File: rtl/z_result_stage.sv
// Result capture stage: waits MUL_WAIT/DIV_WAIT/0 cycles after start, then
// latches the ALU words and holds them under a valid/ready handshake.
// Ports: clock, clear (async active-low), bus (z_result_stage_if.slave).
// Optional macro ZRESULT_HILO_EN: commit MUL/DIV results into hi_reg/lo_reg;
// when undefined, hi_reg/lo_reg read as zero and no HI/LO flops exist.
module z_result_stage #(
    parameter int WIDTH    = 32,
    parameter int MUL_WAIT = 4,
    parameter int DIV_WAIT = 2
) (
    input logic            clock,
    input logic            clear,
    z_result_stage_if.slave bus
);
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam int CMAX = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             commit;
    logic [CW-1:0]    cnt_load;

    always_comb begin
        cnt_load = '0;
        unique case (1'b1)
            (bus.op == OP_MUL): cnt_load = CW'(MUL_WAIT);
            (bus.op == OP_DIV): cnt_load = CW'(DIV_WAIT);
            default:            cnt_load = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        commit  = 1'b0;
        if (bus.flush) begin
            // abort: keep the last captured words, drop the sticky flag
            state_d = S_IDLE;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    accept = bus.start;
                end
                S_WAIT: begin
                    if (bus.start) ovr_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        zhi_d   = bus.alu_hi;
                        zlo_d   = bus.alu_lo;
                        state_d = S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.z_ready) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                        accept  = bus.start;
                    end else if (bus.start) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (accept) begin
                op_d    = bus.op;
                cnt_d   = cnt_load;
                state_d = S_WAIT;
            end
        end
    end

    always_comb begin
        bus.z_valid = (state_q == S_VALID);
        bus.busy    = (state_q != S_IDLE);
        bus.z_hi    = zhi_q;
        bus.z_lo    = zlo_q;
        bus.overrun = ovr_q;
    end

`ifdef ZRESULT_HILO_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             md_op;

    assign md_op = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit && md_op) begin
            hi_q <= zhi_q;
            lo_q <= zlo_q;
        end
    end

    assign bus.hi_reg = hi_q;
    assign bus.lo_reg = lo_q;
`else
    logic unused_hilo;
    assign unused_hilo = ^{op_q, commit};
    assign bus.hi_reg  = '0;
    assign bus.lo_reg  = '0;
`endif

endmodule
